// File: rtl/tl_pkg.sv
// Shared definitions for the traffic sequencer slice.
//   state_e : top-level phase of the intersection
//   step_e  : sub-step inside a timed phase
//   RED/YEL/GRN/OFF : {red, yellow, green} signal head codes
//   WDOG_W  : watchdog counter width
package tl_pkg;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_MAIN_GREEN,
    ST_MAIN_YELLOW,
    ST_RED_MS,
    ST_SIDE_GREEN,
    ST_SIDE_YELLOW,
    ST_RED_SM,
    ST_FAULT
  } state_e;

  // WAIT is split so the first WAIT cycle (expiry blanked) is explicit.
  typedef enum logic [1:0] {
    SS_ARM,
    SS_WAIT_BLANK,
    SS_WAIT,
    SS_HOLD
  } step_e;

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;
  localparam logic [2:0] OFF = 3'b000;

  localparam int unsigned WDOG_W = 6;

endpackage

// File: rtl/tl_watchdog.sv
// Saturating watchdog counter for the timer handshake.
//   clk_1hz : clock
//   rst_n   : synchronous active-low reset
//   clear   : zero the counter (takes priority over enable)
//   enable  : count one cycle, saturating at all-ones
//   trip    : counter has reached LIMIT
module tl_watchdog
  import tl_pkg::*;
#(
  parameter logic [WDOG_W-1:0] LIMIT = 6'd40
) (
  input  logic clk_1hz,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic trip
);

  logic [WDOG_W-1:0] count;

  always_ff @(posedge clk_1hz) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

  assign trip = (count >= LIMIT);

endmodule

// File: rtl/traffic_sequencer.sv
// Two-road intersection sequencer driving both signal heads and a shared
// countdown timer.
//   clk_1hz     : clock
//   rst_n       : synchronous active-low reset
//   side_req    : side-road vehicle sensor (level or pulse)
//   expired     : expiry flag from the shared timer
//   start_timer : one-cycle timer start pulse
//   timer_value : duration of the current phase, stable ARM through WAIT
//   main_light  : main head {red, yellow, green}
//   side_light  : side head {red, yellow, green}
//   fault       : watchdog tripped, sticky until reset
module traffic_sequencer
  import tl_pkg::*;
#(
  parameter logic [3:0]        T_MAIN_GREEN = 4'd8,
  parameter logic [3:0]        T_SIDE_GREEN = 4'd5,
  parameter logic [3:0]        T_YELLOW     = 4'd2,
  parameter logic [3:0]        T_ALL_RED    = 4'd1,
  parameter logic [WDOG_W-1:0] WDOG_LIMIT   = 6'd40
) (
  input  logic       clk_1hz,
  input  logic       rst_n,
  input  logic       side_req,
  input  logic       expired,
  output logic       start_timer,
  output logic [3:0] timer_value,
  output logic [2:0] main_light,
  output logic [2:0] side_light,
  output logic       fault
);

  state_e     state_q, state_d;
  step_e      step_q, step_d;
  logic       req_latch;
  logic       wd_trip, wd_clear, wd_enable;
  logic       start_d, fault_d;
  logic [3:0] value_d;
  logic [2:0] main_d, side_d;

  tl_watchdog #(.LIMIT(WDOG_LIMIT)) u_watchdog (
    .clk_1hz (clk_1hz),
    .rst_n   (rst_n),
    .clear   (wd_clear),
    .enable  (wd_enable),
    .trip    (wd_trip)
  );

  // State register; outputs are registered from the next-state view so the
  // lights change on the same edge that enters ARM.
  always_ff @(posedge clk_1hz) begin
    if (!rst_n) begin
      state_q     <= ST_INIT;
      step_q      <= SS_ARM;
      req_latch   <= 1'b0;
      start_timer <= 1'b0;
      timer_value <= '0;
      main_light  <= RED;
      side_light  <= RED;
      fault       <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      // A new request on the clearing edge wins over the clear.
      req_latch   <= side_req |
                     (req_latch & ~((state_d == ST_SIDE_GREEN) && (step_d == SS_ARM)));
      start_timer <= start_d;
      timer_value <= value_d;
      main_light  <= main_d;
      side_light  <= side_d;
      fault       <= fault_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    case (state_q)
      ST_INIT: begin
        state_d = ST_MAIN_GREEN;
        step_d  = SS_ARM;
      end
      ST_FAULT: ;
      default: begin
        case (step_q)
          SS_ARM:        step_d = SS_WAIT_BLANK;
          SS_WAIT_BLANK: step_d = SS_WAIT;
          SS_WAIT: begin
            if (expired) begin
              step_d = SS_ARM;
              case (state_q)
                ST_MAIN_GREEN: begin
                  if (req_latch) state_d = ST_MAIN_YELLOW;
                  else           step_d  = SS_HOLD;
                end
                ST_MAIN_YELLOW: state_d = ST_RED_MS;
                ST_RED_MS:      state_d = ST_SIDE_GREEN;
                ST_SIDE_GREEN:  state_d = ST_SIDE_YELLOW;
                ST_SIDE_YELLOW: state_d = ST_RED_SM;
                ST_RED_SM:      state_d = ST_MAIN_GREEN;
                default:        state_d = ST_FAULT;
              endcase
            end else if (wd_trip) begin
              state_d = ST_FAULT;
            end
          end
          SS_HOLD: begin
            if (req_latch) begin
              state_d = ST_MAIN_YELLOW;
              step_d  = SS_ARM;
            end
          end
          default: step_d = SS_ARM;
        endcase
      end
    endcase
  end

  // Watchdog counts every WAIT cycle including the one being entered, so it
  // reads k during the k-th WAIT cycle and trips at the end of cycle LIMIT.
  always_comb begin
    wd_clear  = (state_d != ST_FAULT) && (step_d == SS_ARM);
    wd_enable = (state_d != ST_FAULT) && (state_d != ST_INIT) &&
                ((step_d == SS_WAIT_BLANK) || (step_d == SS_WAIT));
  end

  // Output logic (values to be registered on this edge)
  always_comb begin
    start_d = 1'b0;
    value_d = '0;
    main_d  = RED;
    side_d  = RED;
    fault_d = 1'b0;
    case (state_d)
      ST_MAIN_GREEN:  begin value_d = T_MAIN_GREEN; main_d = GRN; end
      ST_MAIN_YELLOW: begin value_d = T_YELLOW;     main_d = YEL; end
      ST_RED_MS:      value_d = T_ALL_RED;
      ST_SIDE_GREEN:  begin value_d = T_SIDE_GREEN; side_d = GRN; end
      ST_SIDE_YELLOW: begin value_d = T_YELLOW;     side_d = YEL; end
      ST_RED_SM:      value_d = T_ALL_RED;
      ST_FAULT: begin
        fault_d = 1'b1;
        // Flash starts on yellow at fault entry, then toggles every cycle.
        main_d  = ((state_q == ST_FAULT) && (main_light == YEL)) ? OFF : YEL;
        side_d  = main_d;
      end
      default: ;
    endcase
    if ((state_d != ST_INIT) && (state_d != ST_FAULT) && (step_d == SS_ARM))
      start_d = 1'b1;
  end

endmodule
